vx_vgpr_req_arbiter: RTL
========================

# vx_vgpr_req_arbiter

Round-robin arbiter that shares one vector register file read port among `NUM_REQS` vector operand collectors in the same issue slice. It registers the winning request toward the VGPR bank, records the winner's index in an in-order tag FIFO, and steers each returning bank response back to that requester one cycle later. It sits between the operand collectors' `vgpr_if` masters and the single VGPR bank read port.

## Interface
- `NUM_REQS`, 4: number of requesting operand collectors (≥2).
- `REQ_DATAW`, 32: packed request payload width (opd_id, sid, wis, lid, reg_id); treated as opaque.
- `RSP_DATAW`, 128: packed response payload width (opd_id + SIMD_WIDTH×XLEN data); treated as opaque.
- `MAX_PENDING`, 4: maximum requests issued but not yet answered, including the one held in the output register; power of two.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `req_valid`  in  NUM_REQS  per-requester request valid.
- `req_data`  in  NUM_REQS×REQ_DATAW  per-requester payload.
- `req_ready`  out  NUM_REQS  one-hot grant; combinational.
- `bank_req_valid`  out  1  registered request to the VGPR bank.
- `bank_req_data`  out  REQ_DATAW  registered payload.
- `bank_req_ready`  in  1  bank accepts the request.
- `bank_rsp_valid`  in  1  bank response valid; no back-pressure.
- `bank_rsp_data`  in  RSP_DATAW  bank response payload.
- `rsp_valid`  out  NUM_REQS  registered one-hot response valid.
- `rsp_data`  out  RSP_DATAW  registered response payload, broadcast to all requesters.
- `pending_cnt`  out  clog2(MAX_PENDING)+1  current outstanding count.
- `rsp_err`  out  1  sticky flag: a response arrived while no request was outstanding.

## Operation
- Output register is free when `!bank_req_valid || bank_req_ready`.
- A grant is allowed when the output register is free, `pending_cnt < MAX_PENDING`, and `reset` is high.
- Round-robin arbitration: search starts at pointer `rr_ptr` and picks the first requester with `req_valid` set. When a grant fires, `rr_ptr` becomes the winner index + 1, modulo NUM_REQS. With no grant, `rr_ptr` holds.
- Grant (`req_valid[i] && req_ready[i]`) does all of the following:
  - loads `bank_req_data` with `req_data[i]`;
  - sets `bank_req_valid`;
  - pushes index `i` into the tag FIFO (depth MAX_PENDING);
  - increments `pending_cnt`.
- If `bank_req_ready` is high and there is no new grant, `bank_req_valid` clears. `bank_req_data` holds while a request is stalled.
- Response with a non-empty FIFO: pop the head tag `h`, then register `rsp_valid = 1<<h` and `rsp_data = bank_rsp_data`, and decrement `pending_cnt`.
- Response with an empty FIFO: set `rsp_err`. No pop, and `rsp_valid` stays 0.
- Grant and response in the same cycle: push and pop both occur and `pending_cnt` is unchanged. A grant while full is impossible by construction.
- Responses return in request order. The bank is required to preserve ordering.

## Timing
- Reset (`reset`==0 at a clock edge) clears:
  - `bank_req_valid`=0, `bank_req_data`=0;
  - `rsp_valid`=0, `rsp_data`=0;
  - `pending_cnt`=0, `rsp_err`=0;
  - `rr_ptr`=0, FIFO emptied.
- `req_ready` is forced to 0 whenever `reset` is low.
- Reset mid-operation discards all outstanding tags. Responses to requests issued before reset then raise `rsp_err`, and integration must drain the bank first.
- Latency: grant in cycle t gives `bank_req_valid` in t+1. `bank_rsp_valid` in cycle t gives `rsp_valid` in t+1.
- `rsp_valid` is a single-cycle pulse per response. Back-to-back responses give back-to-back pulses.
- Throughput: one grant per cycle while `bank_req_ready` stays high and credits remain.
- With `bank_req_ready` low and the register occupied, all `req_ready` bits are 0. The held request stays stable until accepted.

## Test plan
- Single request: req 2 valid with data 0xA5 at t0. Expect `req_ready`=0b0100 at t0, `bank_req_valid`/data 0xA5 at t1. A bank response with 0x77 at t3 gives `rsp_valid`=0b0100 and `rsp_data`=0x77 at t4, and `pending_cnt` returns to 0.
- Fairness: all 4 requesters held valid, bank always ready, responses echoed. Expect grant order 0,1,2,3,0,1… and the matching `rsp_valid` sequence 0b0001, 0b0010, 0b0100, 0b1000.
- Credit limit: all requesters valid, no responses. Expect exactly 4 grants, then `req_ready`=0 and `pending_cnt`=4. After one response, exactly one more grant is made.
- Back-pressure: `bank_req_ready`=0 for 5 cycles after the first grant. Expect `bank_req_data` held, no further grants, and resumption the cycle after ready returns.
- Simultaneous events: with `pending_cnt`=2, a grant and a response in the same cycle. Expect `pending_cnt` to stay 2 and the response to route to the oldest tag.
- Error and reset: a bank response with nothing outstanding sets `rsp_err`=1 with `rsp_valid`=0. Then `reset`=0 for one cycle clears `rsp_err`, `pending_cnt` and `rr_ptr`, and the next grant goes to requester 0.

Source files
------------

// File: rtl/vx_vgpr_req_arbiter.sv
// ============================================================================
// Module   : vx_vgpr_req_arbiter
// Brief    : Round-robin arbiter sharing one VGPR bank read port; routes
//            in-order bank responses back to the originating requester.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vx_vgpr_req_arbiter #(
    parameter int NUM_REQS    = 4,
    parameter int REQ_DATAW   = 32,
    parameter int RSP_DATAW   = 128,
    parameter int MAX_PENDING = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQS-1:0]             req_valid,
    input  logic [NUM_REQS*REQ_DATAW-1:0]   req_data,
    output logic [NUM_REQS-1:0]             req_ready,
    output logic                            bank_req_valid,
    output logic [REQ_DATAW-1:0]            bank_req_data,
    input  logic                            bank_req_ready,
    input  logic                            bank_rsp_valid,
    input  logic [RSP_DATAW-1:0]            bank_rsp_data,
    output logic [NUM_REQS-1:0]             rsp_valid,
    output logic [RSP_DATAW-1:0]            rsp_data,
    output logic [$clog2(MAX_PENDING):0]    pending_cnt,
    output logic                            rsp_err
);

    localparam int c_IDXW  = $clog2(NUM_REQS);
    localparam int c_IDXW1 = c_IDXW + 1;
    localparam int c_PTRW  = $clog2(MAX_PENDING);
    localparam int c_CNTW  = c_PTRW + 1;

    localparam logic [c_IDXW1-1:0] c_NUM_REQS    = c_IDXW1'(NUM_REQS);
    localparam logic [c_IDXW-1:0]  c_LAST_REQ    = c_IDXW'(NUM_REQS - 1);
    localparam logic [c_CNTW-1:0]  c_MAX_PENDING = c_CNTW'(MAX_PENDING);

    logic [c_IDXW-1:0]    rr_ptr_q, rr_ptr_d;
    logic                 bank_req_valid_q, bank_req_valid_d;
    logic [REQ_DATAW-1:0] bank_req_data_q, bank_req_data_d;
    logic [NUM_REQS-1:0]  rsp_valid_q, rsp_valid_d;
    logic [RSP_DATAW-1:0] rsp_data_q, rsp_data_d;
    logic [c_CNTW-1:0]    cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [c_PTRW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PTRW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_IDXW-1:0]    tag_mem_q [MAX_PENDING];

    logic                 out_free;
    logic                 grant;
    logic                 win_found;
    logic [c_IDXW-1:0]    win_idx;
    logic [c_IDXW1-1:0]   cand;
    logic                 push;
    logic                 pop;

    // Rotating priority search starting at rr_ptr_q, wrapping modulo NUM_REQS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = {1'b0, rr_ptr_q} + c_IDXW1'(k);
            if (cand >= c_NUM_REQS) begin
                cand = cand - c_NUM_REQS;
            end
            if (!win_found && req_valid[cand[c_IDXW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[c_IDXW-1:0];
            end
        end
    end

    assign out_free = !bank_req_valid_q || bank_req_ready;
    assign grant    = reset && out_free && (cnt_q < c_MAX_PENDING) && win_found;
    assign push     = grant;
    assign pop      = bank_rsp_valid && (cnt_q != '0);

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d         = rr_ptr_q;
        bank_req_valid_d = bank_req_valid_q;
        bank_req_data_d  = bank_req_data_q;
        rsp_valid_d      = '0;
        rsp_data_d       = rsp_data_q;
        cnt_d            = cnt_q;
        err_d            = err_q | (bank_rsp_valid && (cnt_q == '0));
        wr_ptr_d         = push ? wr_ptr_q + c_PTRW'(1) : wr_ptr_q;
        rd_ptr_d         = pop  ? rd_ptr_q + c_PTRW'(1) : rd_ptr_q;

        if (grant) begin
            rr_ptr_d         = (win_idx == c_LAST_REQ) ? '0 : win_idx + c_IDXW'(1);
            bank_req_valid_d = 1'b1;
            bank_req_data_d  = req_data[win_idx*REQ_DATAW +: REQ_DATAW];
        end else if (bank_req_ready) begin
            bank_req_valid_d = 1'b0;
        end

        if (pop) begin
            rsp_valid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
            rsp_data_d                       = bank_rsp_data;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + c_CNTW'(1);
            2'b01:   cnt_d = cnt_q - c_CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q         <= '0;
            bank_req_valid_q <= 1'b0;
            bank_req_data_q  <= '0;
            rsp_valid_q      <= '0;
            rsp_data_q       <= '0;
            cnt_q            <= '0;
            err_q            <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
        end else begin
            rr_ptr_q         <= rr_ptr_d;
            bank_req_valid_q <= bank_req_valid_d;
            bank_req_data_q  <= bank_req_data_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_data_q       <= rsp_data_d;
            cnt_q            <= cnt_d;
            err_q            <= err_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
        end
    end

    // Tag storage needs no reset: occupancy is tracked solely by cnt_q and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= win_idx;
        end
    end

    assign bank_req_valid = bank_req_valid_q;
    assign bank_req_data  = bank_req_data_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign pending_cnt    = cnt_q;
    assign rsp_err        = err_q;

endmodule

`default_nettype wire
